// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1 -- 8N1 UART receiver.
//
// Samples the asynchronous serial line through a flop synchronizer, finds the
// middle of each bit by counting system clocks, and delivers every good byte
// on rx_msg with a one-cycle rx_complete strobe. A stop bit sampled low
// discards the byte, pulses framing_err and parks the receiver until the line
// returns high. A start bit that is no longer low at its midpoint is treated
// as a glitch and ignored.
//
// Ports
//   clk_50M      in   1  system clock
//   rst_n        in   1  asynchronous active-low reset
//   rx_in        in   1  serial line, asynchronous, idles high
//   rx_msg       out  8  last good byte (LSB received first), held until the next one
//   rx_complete  out  1  one-cycle pulse: rx_msg updated this cycle
//   framing_err  out  1  one-cycle pulse: stop bit was low, byte dropped
//   rx_busy      out  1  high whenever the receiver is not idle
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] rx_msg,
    output logic       rx_complete,
    output logic       framing_err,
    output logic       rx_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   clk_cnt, clk_cnt_n;
    logic [2:0]         bit_idx, bit_idx_n;
    logic [7:0]         shreg, shreg_n;
    logic [7:0]         rx_msg_n;
    logic               rx_complete_n;
    logic               framing_err_n;

    // Synchronizer: presets to the idle level so reset release never looks
    // like a start edge.
    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rx_in};
        end
    end

    assign rx_s = sync[SYNC_STAGES-1];

    // State and datapath registers.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            rx_msg      <= '0;
            rx_complete <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            state       <= state_n;
            clk_cnt     <= clk_cnt_n;
            bit_idx     <= bit_idx_n;
            shreg       <= shreg_n;
            rx_msg      <= rx_msg_n;
            rx_complete <= rx_complete_n;
            framing_err <= framing_err_n;
        end
    end

    // Next-state and next-value logic.
    always_comb begin
        state_n       = state;
        clk_cnt_n     = clk_cnt;
        bit_idx_n     = bit_idx;
        shreg_n       = shreg;
        rx_msg_n      = rx_msg;
        rx_complete_n = 1'b0;
        framing_err_n = 1'b0;

        case (state)
            S_IDLE: begin
                clk_cnt_n = '0;
                if (!rx_s) begin
                    state_n = S_START;
                end
            end

            // Re-check the line at mid start bit; a high level here means the
            // falling edge was noise.
            S_START: begin
                if (clk_cnt == HALF_CNT) begin
                    clk_cnt_n = '0;
                    if (!rx_s) begin
                        state_n   = S_DATA;
                        bit_idx_n = '0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end

            // Counter was aligned to mid start bit, so a full bit period later
            // lands in the middle of each data bit.
            S_DATA: begin
                if (clk_cnt == LAST_CNT) begin
                    clk_cnt_n          = '0;
                    shreg_n[bit_idx]   = rx_s;
                    if (bit_idx == 3'd7) begin
                        state_n = S_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end

            // Leaving for IDLE at mid stop bit gives half a bit of slack for
            // back-to-back frames and transmitter clock skew.
            S_STOP: begin
                if (clk_cnt == LAST_CNT) begin
                    clk_cnt_n = '0;
                    if (rx_s) begin
                        rx_msg_n      = shreg;
                        rx_complete_n = 1'b1;
                        state_n       = S_IDLE;
                    end else begin
                        framing_err_n = 1'b1;
                        state_n       = S_BREAK;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end

            // A line held low must go high before another frame can start.
            S_BREAK: begin
                clk_cnt_n = '0;
                if (rx_s) begin
                    state_n = S_IDLE;
                end
            end

            default: begin
                state_n   = S_IDLE;
                clk_cnt_n = '0;
            end
        endcase
    end

    assign rx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1 -- directed bench for uart_rx_8n1 at 434 clocks per bit.
module tb_uart_rx_8n1;

    localparam int CPB = 434;

    logic       clk_50M;
    logic       rst_n;
    logic       rx_in;
    logic [7:0] rx_msg;
    logic       rx_complete;
    logic       framing_err;
    logic       rx_busy;

    uart_rx_8n1 #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (2)
    ) dut (
        .clk_50M    (clk_50M),
        .rst_n      (rst_n),
        .rx_in      (rx_in),
        .rx_msg     (rx_msg),
        .rx_complete(rx_complete),
        .framing_err(framing_err),
        .rx_busy    (rx_busy)
    );

    initial clk_50M = 1'b0;
    always #10 clk_50M = ~clk_50M;

    // Cycle counter and output monitor.
    int        cyc = 0;
    int        n_comp = 0;
    int        n_ferr = 0;
    int        n_viol = 0;
    int        last_comp_cyc = 0;
    logic [7:0] got [0:63];
    logic      prev_c = 1'b0;
    logic      prev_f = 1'b0;

    always @(posedge clk_50M) cyc <= cyc + 1;

    always @(negedge clk_50M) begin
        if (rst_n) begin
            if (rx_complete) begin
                if (n_comp < 64) got[n_comp] = rx_msg;
                n_comp = n_comp + 1;
                last_comp_cyc = cyc;
            end
            if (framing_err) n_ferr = n_ferr + 1;
            if ((rx_complete && framing_err) ||
                ((rx_complete || framing_err) && (prev_c || prev_f)))
                n_viol = n_viol + 1;
            prev_c = rx_complete;
            prev_f = framing_err;
        end else begin
            prev_c = 1'b0;
            prev_f = 1'b0;
        end
    end

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Hold the line at level b for the given number of clocks; returns #1 after an edge.
    task automatic drive_bit(input logic b, input int period);
        rx_in = b;
        repeat (period) @(posedge clk_50M);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] data, input int period, input logic stop);
        drive_bit(1'b0, period);
        for (int i = 0; i < 8; i++) drive_bit(data[i], period);
        drive_bit(stop, period);
    endtask

    logic [7:0] msg_str [0:7];
    int base_c;
    int base_f;
    int start_cyc;
    int lat;

    initial begin
        msg_str[0] = 8'h49; msg_str[1] = 8'h46; msg_str[2] = 8'h4D; msg_str[3] = 8'h2D;
        msg_str[4] = 8'h45; msg_str[5] = 8'h55; msg_str[6] = 8'h2D; msg_str[7] = 8'h23;

        rst_n = 1'b0;
        rx_in = 1'b1;
        repeat (5) @(posedge clk_50M);
        #1;
        check("reset_rx_msg", {24'd0, rx_msg}, 32'h00);
        check("reset_rx_complete", {31'd0, rx_complete}, 32'd0);
        check("reset_framing_err", {31'd0, framing_err}, 32'd0);
        check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
        rst_n = 1'b1;
        drive_bit(1'b1, 20);

        // Single byte 0x49.
        base_c = n_comp;
        start_cyc = cyc;
        send_byte(8'h49, CPB, 1'b1);
        drive_bit(1'b1, 50);
        check("single_count", n_comp - base_c, 1);
        check("single_msg", {24'd0, rx_msg}, 32'h49);
        check("single_ferr", n_ferr, 0);
        lat = last_comp_cyc - start_cyc;
        check("single_latency_window", {31'd0, (lat >= 4120 && lat <= 4132)}, 32'd1);

        // "IFM-EU-#" with no idle bits between frames.
        base_c = n_comp;
        for (int i = 0; i < 8; i++) send_byte(msg_str[i], CPB, 1'b1);
        drive_bit(1'b1, 50);
        check("b2b_count", n_comp - base_c, 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("b2b_byte%0d", i), {24'd0, got[base_c + i]}, {24'd0, msg_str[i]});

        // Start-bit glitch: 150 cycles low.
        base_c = n_comp;
        base_f = n_ferr;
        drive_bit(1'b0, 100);
        check("glitch_busy_high", {31'd0, rx_busy}, 32'd1);
        drive_bit(1'b0, 50);
        drive_bit(1'b1, 80);
        check("glitch_busy_low", {31'd0, rx_busy}, 32'd0);
        drive_bit(1'b1, 500);
        check("glitch_no_pulse", (n_comp - base_c) + (n_ferr - base_f), 0);

        // Framing error on 0xA5, then a good 0x5A.
        base_c = n_comp;
        base_f = n_ferr;
        send_byte(8'hA5, CPB, 1'b0);
        check("ferr_count", n_ferr - base_f, 1);
        check("ferr_no_complete", n_comp - base_c, 0);
        check("ferr_msg_held", {24'd0, rx_msg}, 32'h23);
        drive_bit(1'b1, 2 * CPB);
        check("ferr_break_exit", {31'd0, rx_busy}, 32'd0);
        send_byte(8'h5A, CPB, 1'b1);
        drive_bit(1'b1, 50);
        check("after_ferr_count", n_comp - base_c, 1);
        check("after_ferr_msg", {24'd0, rx_msg}, 32'h5A);
        check("after_ferr_ferr", n_ferr - base_f, 1);

        // Reset during data bit 4 of 0x3C, then 0xC3.
        base_c = n_comp;
        base_f = n_ferr;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(((8'h3C >> i) & 8'h01) != 0, CPB);
        drive_bit(1'b1, 200);              // bit 4 of 0x3C is 1
        rst_n = 1'b0;
        #5;
        check("midreset_busy", {31'd0, rx_busy}, 32'd0);
        check("midreset_msg", {24'd0, rx_msg}, 32'h00);
        repeat (3) @(posedge clk_50M);
        #1;
        rst_n = 1'b1;
        drive_bit(1'b1, 2 * CPB);
        check("midreset_no_pulse", (n_comp - base_c) + (n_ferr - base_f), 0);
        send_byte(8'hC3, CPB, 1'b1);
        drive_bit(1'b1, 50);
        check("post_reset_count", n_comp - base_c, 1);
        check("post_reset_msg", {24'd0, rx_msg}, 32'hC3);

        // Baud tolerance: 425 then 443 clocks per bit.
        base_c = n_comp;
        send_byte(8'h55, 425, 1'b1);
        drive_bit(1'b1, 50);
        check("fast_msg", {24'd0, rx_msg}, 32'h55);
        send_byte(8'hFF, 443, 1'b1);
        drive_bit(1'b1, 50);
        check("slow_msg", {24'd0, rx_msg}, 32'hFF);
        check("tol_count", n_comp - base_c, 2);
        check("tol_ferr", n_ferr - base_f, 0);

        check("pulse_exclusive", n_viol, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
